// File: rtl/cache_mem_model.sv
// rtl/cache_mem_model.sv - cache storage engine model: word memory, fixed-latency pipeline, credit-backed in-order response queue
//
// cache_resp_queue ports:
//   clk, resetn                 clock, synchronous active-low reset
//   in_tvalid / in_tdata        push one entry (caller guarantees a free slot)
//   out_tvalid / out_tready     head entry present / consumer takes it
//   out_tdata                   registered head entry, zero while empty
//   count                       number of stored entries
//
// cache_mem_model ports:
//   CLK, RST_N                  clock, synchronous active-low reset
//   put_valid / put_ready       request handshake
//   put_request[69:0]           {op[1:0], byte_en[3:0], addr[31:0], data[31:0]}
//   get_valid / get_ready       response handshake (get_valid = consumer take)
//   get_response[51:0]          {op[1:0], addr[17:0], data[31:0]}

module cache_resp_queue #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_tvalid,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    always_comb begin
        pop      = out_tready && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_tvalid) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the count alone, even when full.
        if (in_tvalid && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!in_tvalid && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(in_tvalid && (count_q == FULL_CNT) && !pop));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && in_tvalid) begin
            entry_q[wr_ptr_q] <= in_tdata;
        end
    end

    assign out_tvalid = (count_q != '0);
    assign out_tdata  = out_tvalid ? entry_q[rd_ptr_q] : '0;
    assign count      = count_q;
endmodule

module cache_mem_model #(
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        put_valid,
    input  logic [69:0] put_request,
    output logic        put_ready,
    input  logic        get_valid,
    output logic        get_ready,
    output logic [51:0] get_response
);
    localparam int CNT_W = $clog2(RESP_DEPTH + LATENCY + 1) + 1;
    localparam int WORDS = 1 << ADDR_W;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RESP_DEPTH);

    logic [31:0]       mem_q [WORDS];

    logic [1:0]        req_op;
    logic [3:0]        req_be;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [ADDR_W-1:0] req_idx;
    logic              req_in_range;
    logic              accept;
    logic              mem_wr_en;
    logic [31:0]       mem_rd_word;
    logic [31:0]       mem_wr_word;
    logic [51:0]       acc_resp;

    logic [LATENCY-1:0] stage_valid_q, stage_valid_d;
    logic [51:0]        stage_resp_q [LATENCY];
    logic [51:0]        stage_resp_d [LATENCY];
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               ready_en_q, ready_en_d;
    logic               retire;
    logic [CNT_W-1:0]   queue_count;
    logic [CNT_W:0]     credits_used;

    // Decode and execute at the acceptance edge. The memory read is taken
    // from the array as it stands before this edge, so a store accepted on
    // the previous edge is already visible to a following load.
    always_comb begin
        req_op       = put_request[69:68];
        req_be       = put_request[67:64];
        req_addr     = put_request[63:32];
        req_data     = put_request[31:0];
        req_idx      = req_addr[ADDR_W+1:2];
        req_in_range = (req_addr[31:ADDR_W+2] == '0);

        // Credits count every response that is in flight or queued, so a
        // retiring entry always has a free queue slot waiting for it.
        credits_used = {1'b0, inflight_q} + {1'b0, queue_count};
        put_ready    = ready_en_q && (credits_used < DEPTH_C);
        accept       = put_valid && put_ready && RST_N;

        mem_rd_word = mem_q[req_idx];
        mem_wr_word = mem_rd_word;
        for (int i = 0; i < 4; i++) begin
            if (req_be[i]) begin
                mem_wr_word[8*i +: 8] = req_data[8*i +: 8];
            end
        end
        mem_wr_en = accept && req_in_range && (req_op == 2'd1);

        if (!req_in_range || (req_op == 2'd3)) begin
            acc_resp = {2'd3, req_addr[17:0], 32'hDEAD_BEEF};
        end else if (req_op == 2'd0) begin
            acc_resp = {2'd0, req_addr[17:0], mem_rd_word};
        end else begin
            acc_resp = {req_op, req_addr[17:0], 32'h0};
        end
    end

    // Delay line: stage k holds a response accepted k+1 edges ago; the last
    // stage retires into the queue on the next edge.
    always_comb begin
        stage_valid_d[0] = accept;
        stage_resp_d[0]  = acc_resp;
        for (int k = 1; k < LATENCY; k++) begin
            stage_valid_d[k] = stage_valid_q[k-1];
            stage_resp_d[k]  = stage_resp_q[k-1];
        end
        retire     = stage_valid_q[LATENCY-1];
        inflight_d = inflight_q;
        if (accept && !retire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && retire) begin
            inflight_d = inflight_q - 1'b1;
        end
        ready_en_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stage_valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                stage_resp_q[k] <= '0;
            end
            inflight_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            for (int k = 0; k < LATENCY; k++) begin
                stage_resp_q[k] <= stage_resp_d[k];
            end
            inflight_q <= inflight_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Backing storage keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (mem_wr_en) begin
            mem_q[req_idx] <= mem_wr_word;
        end
    end

    cache_resp_queue #(
        .WIDTH (52),
        .DEPTH (RESP_DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_queue (
        .clk        (CLK),
        .resetn     (RST_N),
        .in_tvalid  (retire),
        .in_tdata   (stage_resp_q[LATENCY-1]),
        .out_tvalid (get_ready),
        .out_tready (get_valid),
        .out_tdata  (get_response),
        .count      (queue_count)
    );
endmodule
